// File: rtl/spi_master_if.sv
// Host command/response and SPI pin bundle for spi_master.
// master: the spi_master's view; slave: the host/SPI-slave side.
interface spi_master_if;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic       busy;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       cmd_err;
  logic       ss_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, busy, rd_valid, rd_data, cmd_err, ss_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, busy, rd_valid, rd_data, cmd_err, ss_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// SPI master for 10-bit {cmd,payload} frames, MSB first, one bit per clock; captures 8-bit reply on read-data.
// Optional read-order checking is enabled by defining SPI_MASTER_ORDER_CHK_EN.
module spi_master #(
  parameter int RD_TURNAROUND = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, CAPTURE, GAP} state_t;

  localparam logic [3:0] TURN_LAST = 4'(RD_TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [9:0] shreg;
  logic [3:0] cnt;
  logic [7:0] cap;
  logic       rd_cmd;
`ifdef SPI_MASTER_ORDER_CHK_EN
  logic       rd_addr_sent;
`endif

  // Single-process FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= 10'd0;
      cnt           <= 4'd0;
      cap           <= 8'd0;
      rd_cmd        <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= 8'h00;
      bus.cmd_err   <= 1'b0;
      bus.ss_n      <= 1'b1;
      bus.MOSI      <= 1'b0;
`ifdef SPI_MASTER_ORDER_CHK_EN
      rd_addr_sent  <= 1'b0;
`endif
    end else begin
      bus.rd_valid <= 1'b0;
      bus.cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            shreg         <= bus.cmd_data;
            rd_cmd        <= (bus.cmd_data[9:8] == 2'b11);
            cnt           <= 4'd0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
`ifdef SPI_MASTER_ORDER_CHK_EN
            // A read-data without a preceding read-address is dropped, never framed.
            if ((bus.cmd_data[9:8] == 2'b11) && !rd_addr_sent) begin
              state       <= GAP;
              bus.cmd_err <= 1'b1;
            end else begin
              if (bus.cmd_data[9:8] == 2'b10) begin
                rd_addr_sent <= 1'b1;
              end
              state    <= START;
              bus.ss_n <= 1'b0;
              bus.MOSI <= bus.cmd_data[9];
            end
`else
            state    <= START;
            bus.ss_n <= 1'b0;
            bus.MOSI <= bus.cmd_data[9];
`endif
          end
        end
        START: begin
          bus.MOSI <= shreg[9];
          shreg    <= {shreg[8:0], 1'b0};
          cnt      <= 4'd0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (cnt == 4'd9) begin
            bus.MOSI <= 1'b0;
            cnt      <= 4'd0;
            if (rd_cmd) begin
              state <= TURN;
            end else begin
              state    <= GAP;
              bus.ss_n <= 1'b1;
            end
          end else begin
            bus.MOSI <= shreg[9];
            shreg    <= {shreg[8:0], 1'b0};
            cnt      <= cnt + 4'd1;
          end
        end
        TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= 4'd0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CAPTURE: begin
          cap <= {cap[6:0], bus.MISO};
          if (cnt == 4'd7) begin
            bus.rd_data  <= {cap[6:0], bus.MISO};
            bus.rd_valid <= 1'b1;
            bus.ss_n     <= 1'b1;
            cnt          <= 4'd0;
            state        <= GAP;
`ifdef SPI_MASTER_ORDER_CHK_EN
            rd_addr_sent <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state         <= IDLE;
          cnt           <= 4'd0;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
          bus.ss_n      <= 1'b1;
          bus.MOSI      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: the bench plays the SPI slave + RAM and predicts every frame.
module tb_spi_master;
  localparam int T  = 3;
  localparam int G  = 2;
  localparam int NW = 19 + T + G + 2;
`ifdef SPI_MASTER_ORDER_CHK_EN
  localparam bit ORDER_CHK = 1'b1;
`else
  localparam bit ORDER_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if bus ();
  spi_master #(.RD_TURNAROUND(T), .GAP_CYCLES(G)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];
  logic [7:0] waddr, raddr, exp_rd;
  bit rd_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_send", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Issue one command and check the whole frame against the model.
  task automatic send(input logic [9:0] c);
    int low_len, ss_bad, ready_idx, rv_cnt, rv_idx, err_cnt, err_idx, busy_bad, mosi_extra, exp_len, bi;
    logic [10:0] mosi_obs, mosi_exp;
    logic [7:0] reply;
    bit xmit, is_rd;
    xmit    = !(ORDER_CHK && c[9:8] == 2'b11 && !rd_flag);
    is_rd   = xmit && (c[9:8] == 2'b11);
    reply   = mem[raddr];
    exp_len = !xmit ? 0 : (is_rd ? 19 + T : 11);
    mosi_exp = xmit ? {c[9], c} : 11'd0;

    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    low_len = 0; ss_bad = 0; ready_idx = -1; rv_cnt = 0; rv_idx = -1;
    err_cnt = 0; err_idx = -1; busy_bad = 0; mosi_extra = 0; mosi_obs = 11'd0;
    for (int i = 0; i < NW; i++) begin
      if (i >= 11 + T && i <= 18 + T) begin
        bi = 18 + T - i;
        bus.MISO = reply[bi];
      end else begin
        bus.MISO = 1'b0;
      end
      if (bus.ss_n === 1'b0) low_len++;
      if (bus.ss_n !== ((i < exp_len) ? 1'b0 : 1'b1)) ss_bad++;
      if (i < 11) mosi_obs[10 - i] = bus.MOSI;
      else if (bus.MOSI !== 1'b0) mosi_extra++;
      if (bus.rd_valid === 1'b1) begin rv_cnt++; rv_idx = i; end
      if (bus.cmd_err === 1'b1) begin err_cnt++; err_idx = i; end
      if (bus.cmd_ready === 1'b1 && ready_idx < 0) ready_idx = i;
      if (bus.busy !== ((ready_idx < 0) ? 1'b1 : 1'b0)) busy_bad++;
      @(negedge clk);
    end
    bus.MISO = 1'b0;

    chk("ss_n_low_cycles", low_len, exp_len);
    chk("ss_n_pattern", ss_bad, 0);
    chk("mosi_bits", {21'd0, mosi_obs}, {21'd0, mosi_exp});
    chk("mosi_idle_zero", mosi_extra, 0);
    chk("rd_valid_count", rv_cnt, is_rd ? 1 : 0);
    if (is_rd) chk("rd_valid_cycle", rv_idx, 19 + T);
    chk("cmd_err_count", err_cnt, xmit ? 0 : 1);
    if (!xmit) chk("cmd_err_cycle", err_idx, 0);
    chk("ready_return_cycle", ready_idx, exp_len + G);
    chk("busy_pattern", busy_bad, 0);

    if (xmit) begin
      case (c[9:8])
        2'b00: waddr = c[7:0];
        2'b01: mem[waddr] = c[7:0];
        2'b10: begin raddr = c[7:0]; rd_flag = 1'b1; end
        default: begin exp_rd = reply; rd_flag = 1'b0; end
      endcase
    end
    chk("rd_data_hold", {24'd0, bus.rd_data}, {24'd0, exp_rd});
  endtask

  initial begin
    logic [9:0] c;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 10'd0;
    bus.MISO      = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    waddr = 8'd0; raddr = 8'd0; exp_rd = 8'd0; rd_flag = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ss_n", {31'd0, bus.ss_n}, 32'd1);
    chk("rst_mosi", {31'd0, bus.MOSI}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_cmd_err", {31'd0, bus.cmd_err}, 32'd0);

    // cmd_valid together with rst must be ignored
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 10'h3A5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("valid_in_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("valid_in_rst_ss_n", {31'd0, bus.ss_n}, 32'd1);

    send(10'b11_0000_0000);
    send(10'b00_1010_0101);
    send({2'b00, 8'h3C});
    send({2'b01, 8'hA7});
    send({2'b10, 8'h3C});
    send({2'b11, 8'h00});
    chk("directed_read_A7", {24'd0, bus.rd_data}, 32'h0000_00A7);
    send({2'b00, 8'h10});
    send({2'b01, 8'h5A});
    send({2'b10, 8'h10});
    send({2'b11, 8'h00});
    chk("directed_read_5A", {24'd0, bus.rd_data}, 32'h0000_005A);

    // reset while payload bit 4 of a write-data frame is on MOSI
    wait_ready();
    c = {2'b01, 8'hD3};
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mosi_bit4_before_rst", {31'd0, bus.MOSI}, {31'd0, c[4]});
    chk("ss_n_low_before_rst", {31'd0, bus.ss_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ss_n", {31'd0, bus.ss_n}, 32'd1);
    chk("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("midrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    exp_rd  = 8'd0;
    rd_flag = 1'b0;
    send({2'b00, 8'h77});

    repeat (30) begin
      c = {2'($urandom_range(0, 3)), 8'($urandom)};
      send(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
